cve2_rf_wb_arbiter: RTL
=======================

Name: cve2_rf_wb_arbiter

Overview:
- Shares the register file's single write port (waddr/wdata/we) between two writeback sources.
  - EX: single-cycle ALU/CSR results; can be backpressured.
  - LSU: load returns; cannot be stalled.
- Holds one EX result in a hold buffer when the two sources collide.
- Keeps a scoreboard of registers with loads in flight, and flags read hazards to the ID stage.
- Sits between the writeback stage and the register file write port.

Parameters:
- RV32E, 0, 1 selects 16 architectural registers (address bit 4 ignored); 0 selects 32.
- DataWidth, 32, width of the write data path.

Ports:
- clk_int  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- ex_req_i  in  1  EX result valid
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX result data
- ex_gnt_o  out  1  EX result accepted this cycle (combinational)
- lsu_req_i  in  1  load data returning; must be written this cycle
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DataWidth  load data
- ld_issue_i  in  1  load issued to LSU
- ld_issue_rd_i  in  5  destination register of the issued load
- raddr_a_i  in  5  ID read address, port A
- raddr_b_i  in  5  ID read address, port B
- hazard_o  out  1  a read address hits a pending register (combinational)
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data

Behaviour:
- Reset state:
  - Hold buffer EMPTY, holding address and data 0.
  - Scoreboard cleared.
  - Outputs follow from this state: rf_we_o=0, ex_gnt_o=0, hazard_o=0 while no requests are present.
- Address handling:
  - The effective address is addr[ADDR_W-1:0], with ADDR_W = RV32E ? 4 : 5.
  - A request to x0 is granted/consumed but never produces rf_we_o and never touches the scoreboard or hold buffer.
- Write-port priority: LSU > hold buffer > EX direct.
- Write-port outputs are combinational, so the register file samples them at the next clk_int edge.
  - Direct writes have zero added latency.
  - Held writes have one or more cycles of added latency.
- Hold buffer state machine, EMPTY/FULL:
  - EMPTY, no lsu_req: EX passes directly to the port. ex_gnt_o=ex_req_i. State stays EMPTY.
  - EMPTY, lsu_req: LSU writes. If ex_req_i, the EX request is captured into hold, ex_gnt_o=1, next state FULL.
  - FULL, no lsu_req: the hold entry writes. If ex_req_i, the new request is captured into hold (replace), ex_gnt_o=1, state stays FULL. Otherwise next state EMPTY.
  - FULL, lsu_req: LSU writes and the hold entry stays. ex_gnt_o=0.
- Scoreboard (bit per register, bit 0 is constant 0):
  - Set on ld_issue_i to ld_issue_rd_i.
  - Cleared when the LSU write to that register occurs.
  - If set and clear hit the same register in the same cycle, set wins.
- hazard_o asserts if raddr_a_i or raddr_b_i (non-zero) matches either of:
  - a scoreboard bit that is set;
  - the hold entry address while FULL.
- An EX request whose address has its scoreboard bit set is illegal; this is covered by an assertion.
- An LSU return to a register whose scoreboard bit is clear is illegal; this is covered by an assertion.
- Reset asserted mid-operation:
  - Held data is discarded and the scoreboard is cleared immediately (asynchronous reset).
  - No rf_we_o while rst_ni is low.

Decomposition:
- cve2_pkg gets:
  - the RF_ADDR_W function of RV32E;
  - the hold_state_e typedef {HOLD_EMPTY, HOLD_FULL};
  - a wb_req_t struct {valid, waddr, wdata}.
- One sub-module, cve2_rf_scoreboard. It contains the set/clear bit vector and two read-port match outputs, parameterised by RV32E.
- The hold buffer and priority mux stay in the top module.

Test Plan:
- EX-only writes, EX waddr=3, wdata=0xA5A5_0001 -> rf_we_o=1, rf_waddr_o=3, same cycle; ex_gnt_o=1; hold stays EMPTY.
- Collision, LSU rd=7 and EX rd=9 in the same cycle:
  - Cycle n: rf_waddr_o=7, ex_gnt_o=1.
  - Cycle n+1: rf_waddr_o=9 with the EX data.
  - hazard_o=1 for raddr_a_i=9 during cycle n+1's pre-write window.
- Hold FULL, with lsu_req for two consecutive cycles plus a new EX request:
  - ex_gnt_o=0 for both cycles.
  - The held entry writes in the third cycle and the new EX request is captured at the same time.
- Scoreboard, ld_issue to rd=12:
  - raddr_b_i=12 -> hazard_o=1 until the LSU returns rd=12; hazard_o=0 the following cycle.
  - Same-cycle reissue to rd=12 during the return keeps hazard_o=1.
- x0 and RV32E:
  - EX waddr=0 -> ex_gnt_o=1, rf_we_o=0.
  - With RV32E=1, ld_issue_rd_i=17 marks register 1, and raddr_a_i=1 gives hazard_o=1.
- Reset mid-operation: hold FULL with scoreboard bit 5 set, pulse rst_ni low -> rf_we_o=0, hazard_o=0 on raddr 5, and ex_gnt_o follows the EMPTY rule after release.

Source files
------------

// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared types and helpers for the register-file writeback arbiter
package cve2_pkg;

   // Widest write data the hold entry can carry; DataWidth must not exceed it.
   localparam int unsigned WB_DATA_W = 32;

   function automatic int unsigned RF_ADDR_W(input bit rv32e);
      return rv32e ? 4 : 5;
   endfunction

   typedef enum logic [0:0] {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_e;

   typedef struct packed {
      logic                 valid;
      logic [4:0]           waddr;
      logic [WB_DATA_W-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/cve2_rf_scoreboard.sv
// rtl/cve2_rf_scoreboard.sv - pending-load bit per register with two read-port match outputs
module cve2_rf_scoreboard
   import cve2_pkg::*;
#(
   parameter bit RV32E = 1'b0,
   localparam int unsigned AW = RF_ADDR_W(RV32E),
   localparam int unsigned NR = 1 << AW
) (
   input  logic          clk_int,
   input  logic          rst_ni,
   input  logic          set,
   input  logic [AW-1:0] set_addr,
   input  logic          clr,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic          match_a,
   output logic          match_b,
   output logic [NR-1:0] pend
);

   logic [NR-1:1] bits_q;
   logic [NR-1:1] bits_d;

   // Set is applied after clear so a same-cycle reissue keeps the register pending.
   always_comb begin
      bits_d = bits_q;
      for (int i = 1; i < NR; i++) begin
         if (clr && (clr_addr == AW'(i))) bits_d[i] = 1'b0;
         if (set && (set_addr == AW'(i))) bits_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         bits_q <= '0;
      end else begin
         bits_q <= bits_d;
      end
   end

   assign pend    = {bits_q, 1'b0};
   assign match_a = pend[raddr_a];
   assign match_b = pend[raddr_b];

endmodule

// File: rtl/cve2_rf_wb_arbiter.sv
// rtl/cve2_rf_wb_arbiter.sv - shares the RF write port between EX results and load returns
module cve2_rf_wb_arbiter
   import cve2_pkg::*;
#(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_int,
   input  logic                 rst_ni,
   input  logic                 ex_req_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_gnt_o,
   input  logic                 lsu_req_i,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   input  logic                 ld_issue_i,
   input  logic [4:0]           ld_issue_rd_i,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o
);

   localparam int unsigned AW = RF_ADDR_W(RV32E);
   localparam int unsigned NR = 1 << AW;

   logic [AW-1:0] ex_addr, lsu_addr, ld_addr, ra_addr, rb_addr;
   logic          unused_addr_hi;

   assign ex_addr  = ex_waddr_i[AW-1:0];
   assign lsu_addr = lsu_waddr_i[AW-1:0];
   assign ld_addr  = ld_issue_rd_i[AW-1:0];
   assign ra_addr  = raddr_a_i[AW-1:0];
   assign rb_addr  = raddr_b_i[AW-1:0];
   assign unused_addr_hi = ^{ex_waddr_i[4], lsu_waddr_i[4], ld_issue_rd_i[4],
                             raddr_a_i[4], raddr_b_i[4]};

   wb_req_t ex_s, lsu_s, hold_q, hold_d, port;
   hold_state_e state_q, state_d;
   logic gnt;

   always_comb begin
      ex_s       = '0;
      ex_s.valid = ex_req_i && (ex_addr != '0);
      ex_s.waddr = 5'(ex_addr);
      ex_s.wdata = WB_DATA_W'(ex_wdata_i);
      lsu_s       = '0;
      lsu_s.valid = lsu_req_i && (lsu_addr != '0);
      lsu_s.waddr = 5'(lsu_addr);
      lsu_s.wdata = WB_DATA_W'(lsu_wdata_i);
   end

   // Priority LSU > hold > EX; x0 requests are granted but never captured.
   always_comb begin
      port    = '0;
      gnt     = 1'b0;
      hold_d  = hold_q;
      state_d = state_q;
      unique case (state_q)
         HOLD_EMPTY: begin
            gnt = ex_req_i;
            if (lsu_req_i) begin
               port = lsu_s;
               if (ex_s.valid) begin
                  hold_d  = ex_s;
                  state_d = HOLD_FULL;
               end
            end else begin
               port = ex_s;
            end
         end
         HOLD_FULL: begin
            if (lsu_req_i) begin
               port = lsu_s;
            end else begin
               port = hold_q;
               gnt  = ex_req_i;
               if (ex_s.valid) begin
                  hold_d = ex_s;
               end else begin
                  hold_d  = '0;
                  state_d = HOLD_EMPTY;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= HOLD_EMPTY;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign rf_we_o    = port.valid & rst_ni;
   assign rf_waddr_o = port.waddr;
   assign rf_wdata_o = DataWidth'(port.wdata);
   assign ex_gnt_o   = gnt & rst_ni;

   logic          sb_match_a, sb_match_b;
   logic [NR-1:0] pend;

   cve2_rf_scoreboard #(
      .RV32E(RV32E)
   ) u_scoreboard (
      .clk_int (clk_int),
      .rst_ni  (rst_ni),
      .set     (ld_issue_i),
      .set_addr(ld_addr),
      .clr     (lsu_req_i),
      .clr_addr(lsu_addr),
      .raddr_a (ra_addr),
      .raddr_b (rb_addr),
      .match_a (sb_match_a),
      .match_b (sb_match_b),
      .pend    (pend)
   );

   logic hold_hit_a, hold_hit_b;

   assign hold_hit_a = (state_q == HOLD_FULL) && (ra_addr != '0) && (5'(ra_addr) == hold_q.waddr);
   assign hold_hit_b = (state_q == HOLD_FULL) && (rb_addr != '0) && (5'(rb_addr) == hold_q.waddr);
   assign hazard_o   = sb_match_a | sb_match_b | hold_hit_a | hold_hit_b;

   ex_to_pending_reg: assert property (@(posedge clk_int) disable iff (!rst_ni)
      (ex_req_i && (ex_addr != '0)) |-> !pend[ex_addr]);

   lsu_to_idle_reg: assert property (@(posedge clk_int) disable iff (!rst_ni)
      (lsu_req_i && (lsu_addr != '0)) |-> pend[lsu_addr]);

endmodule
